// File: rtl/chunk_row_sched.sv
// Round-robin arbiter sharing one chunk row-start datapath between NREQ requesters; optional perf counters via CHUNK_ROW_SCHED_PERF_EN.
// Latency: grant -> o_dp_rdy 1 cycle; row path is a zero-latency combinational passthrough to the owner.
// Backpressure: o_dp_rdy holds with o_dp_cfg stable until i_dp_ack; rows stall on the owner's i_req_row_ack, non-owner acks ignored.
module chunk_row_sched #(
    parameter int NREQ   = 2,
    parameter int GBW    = 32,
    parameter int DIM    = 3,
    parameter int VSIZE  = 8,
    localparam int V_BW   = (VSIZE > 1) ? $clog2(VSIZE) : 1,
    localparam int CFG_BW = 3*DIM*GBW + DIM*V_BW + GBW + 1,
    localparam int PW     = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic                           i_clk,
    input  logic                           i_rst,
    input  logic [NREQ-1:0]                i_req_rdy,
    output logic [NREQ-1:0]                o_req_ack,
    input  logic [NREQ-1:0][CFG_BW-1:0]    i_req_cfg,
    output logic                           o_dp_rdy,
    input  logic                           i_dp_ack,
    output logic [CFG_BW-1:0]              o_dp_cfg,
    input  logic                           i_row_rdy,
    output logic                           o_row_ack,
    input  logic [GBW-1:0]                 i_row_linear,
    input  logic                           i_row_islast,
    input  logic [V_BW-1:0]                i_row_pad,
    input  logic                           i_row_valid,
    output logic [NREQ-1:0]                o_req_row_rdy,
    input  logic [NREQ-1:0]                i_req_row_ack,
    output logic [GBW-1:0]                 o_req_row_linear,
    output logic                           o_req_row_islast,
    output logic [V_BW-1:0]                o_req_row_pad,
    output logic                           o_req_row_valid,
    output logic                           o_busy
`ifdef CHUNK_ROW_SCHED_PERF_EN
    ,
    output logic [NREQ-1:0][31:0]          o_perf_rows,
    output logic [NREQ-1:0][31:0]          o_perf_wait
`endif
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    state_t            state, state_nxt;
    logic [PW-1:0]     ptr, ptr_nxt;
    logic [PW-1:0]     owner, owner_nxt;
    logic [PW-1:0]     owner_inc;
    logic [CFG_BW-1:0] cfg_q, cfg_nxt;

    logic              found_hi, found_lo, grant_found;
    logic [PW-1:0]     idx_hi, idx_lo, grant_idx;
    logic              row_xfer;

    // Round-robin search: lowest ready index at or above ptr wins, else lowest below ptr (wrap).
    always_comb begin
        found_hi = 1'b0;
        found_lo = 1'b0;
        idx_hi   = '0;
        idx_lo   = '0;
        for (int j = NREQ-1; j >= 0; j--) begin
            if (i_req_rdy[j]) begin
                if (j >= int'(ptr)) begin
                    found_hi = 1'b1;
                    idx_hi   = PW'(j);
                end else begin
                    found_lo = 1'b1;
                    idx_lo   = PW'(j);
                end
            end
        end
        grant_found = found_hi | found_lo;
        grant_idx   = found_hi ? idx_hi : idx_lo;
    end

    // Explicit wrap keeps ptr legal for non-power-of-2 NREQ.
    assign owner_inc = (owner == PW'(NREQ-1)) ? '0 : owner + PW'(1);

    // A row moves only when the datapath offers it and the owning requester takes it.
    assign row_xfer = (state == ST_DRAIN) && i_row_rdy && i_req_row_ack[owner];

    // Next-state and handshake outputs; grants are suppressed while reset is asserted.
    always_comb begin
        state_nxt     = state;
        ptr_nxt       = ptr;
        owner_nxt     = owner;
        cfg_nxt       = cfg_q;
        o_req_ack     = '0;
        o_dp_rdy      = 1'b0;
        o_row_ack     = 1'b0;
        o_req_row_rdy = '0;
        unique case (state)
            ST_IDLE: begin
                if (grant_found && !i_rst) begin
                    o_req_ack[grant_idx] = 1'b1;
                    cfg_nxt              = i_req_cfg[grant_idx];
                    owner_nxt            = grant_idx;
                    state_nxt            = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                o_dp_rdy = 1'b1;
                if (i_dp_ack) begin
                    state_nxt = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                o_req_row_rdy[owner] = i_row_rdy;
                o_row_ack            = i_req_row_ack[owner];
                if (row_xfer && i_row_islast) begin
                    ptr_nxt   = owner_inc;
                    state_nxt = ST_IDLE;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // State, round-robin pointer, owner and held config registers.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state <= ST_IDLE;
            ptr   <= '0;
            owner <= '0;
            cfg_q <= '0;
        end else begin
            state <= state_nxt;
            ptr   <= ptr_nxt;
            owner <= owner_nxt;
            cfg_q <= cfg_nxt;
        end
    end

    assign o_dp_cfg         = cfg_q;
    assign o_busy           = (state != ST_IDLE);
    assign o_req_row_linear = i_row_linear;
    assign o_req_row_islast = i_row_islast;
    assign o_req_row_pad    = i_row_pad;
    assign o_req_row_valid  = i_row_valid;

`ifdef CHUNK_ROW_SCHED_PERF_EN
    logic [NREQ-1:0][31:0] perf_rows_q;
    logic [NREQ-1:0][31:0] perf_wait_q;

    // Saturating per-requester counters: rows delivered and cycles spent waiting for a grant.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            perf_rows_q <= '0;
            perf_wait_q <= '0;
        end else begin
            for (int i = 0; i < NREQ; i++) begin
                if (row_xfer && (owner == PW'(i)) && (perf_rows_q[i] != '1)) begin
                    perf_rows_q[i] <= perf_rows_q[i] + 32'd1;
                end
                if (i_req_rdy[i] && !o_req_ack[i] && (perf_wait_q[i] != '1)) begin
                    perf_wait_q[i] <= perf_wait_q[i] + 32'd1;
                end
            end
        end
    end

    assign o_perf_rows = perf_rows_q;
    assign o_perf_wait = perf_wait_q;
`else
    // Counters compiled out; grant and row paths are unaffected.
`endif

`ifndef SYNTHESIS
    // At most one requester is granted per cycle.
    a_ack_onehot: assert property (@(posedge i_clk) disable iff (i_rst)
        $onehot0(o_req_ack));

    // The offered config must not move while the datapath has yet to take it.
    a_cfg_stable: assert property (@(posedge i_clk) disable iff (i_rst)
        (o_dp_rdy && $past(o_dp_rdy)) |-> $stable(o_dp_cfg));

    // The datapath only produces rows after it has accepted a config.
    a_row_in_drain: assert property (@(posedge i_clk) disable iff (i_rst)
        !(i_row_rdy && (state != ST_DRAIN)));
`endif

endmodule

// File: tb/tb_chunk_row_sched.sv
module tb_chunk_row_sched;

    localparam int NREQ   = 2;
    localparam int GBW    = 16;
    localparam int DIM    = 2;
    localparam int VSIZE  = 8;
    localparam int V_BW   = 3;
    localparam int CFG_BW = 3*DIM*GBW + DIM*V_BW + GBW + 1;

    logic                        i_clk = 1'b0;
    logic                        i_rst;
    logic [NREQ-1:0]             i_req_rdy;
    logic [NREQ-1:0]             o_req_ack;
    logic [NREQ-1:0][CFG_BW-1:0] i_req_cfg;
    logic                        o_dp_rdy;
    logic                        i_dp_ack;
    logic [CFG_BW-1:0]           o_dp_cfg;
    logic                        i_row_rdy;
    logic                        o_row_ack;
    logic [GBW-1:0]              i_row_linear, o_req_row_linear;
    logic                        i_row_islast, o_req_row_islast;
    logic [V_BW-1:0]             i_row_pad, o_req_row_pad;
    logic                        i_row_valid, o_req_row_valid;
    logic [NREQ-1:0]             o_req_row_rdy;
    logic [NREQ-1:0]             i_req_row_ack;
    logic                        o_busy;
`ifdef CHUNK_ROW_SCHED_PERF_EN
    logic [NREQ-1:0][31:0]       o_perf_rows;
    logic [NREQ-1:0][31:0]       o_perf_wait;
`endif

    // Datapath model: rows are either driven explicitly or auto-offered whenever the DUT drains.
    logic row_rdy_drv;
    logic auto_row;
    assign i_row_rdy = row_rdy_drv | (auto_row & o_busy & ~o_dp_rdy);

    typedef struct {
        int             own;
        logic [GBW-1:0] lin;
        logic [V_BW-1:0] pad;
    } row_t;

    int              checks = 0;
    int              errors = 0;
    int              exp_grant[$];
    row_t            exp_row[$];
    logic [NREQ-1:0] exp_ack[$];

    always #5 i_clk = ~i_clk;

    chunk_row_sched #(.NREQ(NREQ), .GBW(GBW), .DIM(DIM), .VSIZE(VSIZE)) dut (
        .i_clk            (i_clk),
        .i_rst            (i_rst),
        .i_req_rdy        (i_req_rdy),
        .o_req_ack        (o_req_ack),
        .i_req_cfg        (i_req_cfg),
        .o_dp_rdy         (o_dp_rdy),
        .i_dp_ack         (i_dp_ack),
        .o_dp_cfg         (o_dp_cfg),
        .i_row_rdy        (i_row_rdy),
        .o_row_ack        (o_row_ack),
        .i_row_linear     (i_row_linear),
        .i_row_islast     (i_row_islast),
        .i_row_pad        (i_row_pad),
        .i_row_valid      (i_row_valid),
        .o_req_row_rdy    (o_req_row_rdy),
        .i_req_row_ack    (i_req_row_ack),
        .o_req_row_linear (o_req_row_linear),
        .o_req_row_islast (o_req_row_islast),
        .o_req_row_pad    (o_req_row_pad),
        .o_req_row_valid  (o_req_row_valid),
        .o_busy           (o_busy)
`ifdef CHUNK_ROW_SCHED_PERF_EN
        ,
        .o_perf_rows      (o_perf_rows),
        .o_perf_wait      (o_perf_wait)
`endif
    );

    function automatic logic [CFG_BW-1:0] mk_cfg(input logic [GBW-1:0] maddr, input logic [7:0] tag);
        logic [CFG_BW-1:0] c;
        c               = '0;
        c[GBW:1]        = maddr;
        c[CFG_BW-1 -: 8] = tag;
        c[0]            = tag[0];
        return c;
    endfunction

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic test_reset();
        int g;
        i_rst         = 1'b1;
        i_req_rdy     = '1;
        i_req_cfg[0]  = mk_cfg(16'h0010, 8'h01);
        i_req_cfg[1]  = mk_cfg(16'h0011, 8'h02);
        i_dp_ack      = 1'b0;
        row_rdy_drv   = 1'b0;
        auto_row      = 1'b0;
        i_row_linear  = '0;
        i_row_islast  = 1'b0;
        i_row_pad     = '0;
        i_row_valid   = 1'b0;
        i_req_row_ack = '0;
        tick();
        tick();
        #1;
        checks++;
        if (o_req_ack !== 2'b00 || o_dp_rdy !== 1'b0 || o_busy !== 1'b0 ||
            o_req_row_rdy !== 2'b00 || o_row_ack !== 1'b0 || o_dp_cfg !== '0) begin
            errors++;
            $display("FAIL reset_outputs: ack=%b dp_rdy=%b busy=%b row_rdy=%b row_ack=%b cfg_nz=%b, want all 0",
                     o_req_ack, o_dp_rdy, o_busy, o_req_row_rdy, o_row_ack, |o_dp_cfg);
        end
        exp_grant.push_back(0);
        i_rst = 1'b0;
        #1;
        g = exp_grant.pop_front();
        checks++;
        if (o_req_ack !== (NREQ'(1) << g)) begin
            errors++;
            $display("FAIL reset_first_grant: got %b want %b", o_req_ack, NREQ'(1) << g);
        end
        tick();
        i_req_rdy = '0;
        #1;
        checks++;
        if (o_dp_rdy !== 1'b1 || o_dp_cfg[GBW:1] !== 16'h0010) begin
            errors++;
            $display("FAIL reset_issue: dp_rdy=%b maddr=%h want 1 / 0010", o_dp_rdy, o_dp_cfg[GBW:1]);
        end
        i_dp_ack = 1'b1;
        tick();
        i_dp_ack      = 1'b0;
        row_rdy_drv   = 1'b1;
        i_row_islast  = 1'b1;
        i_req_row_ack = 2'b01;
        #1;
        checks++;
        if (o_req_row_rdy !== 2'b01) begin
            errors++;
            $display("FAIL reset_row_owner: got %b want 01", o_req_row_rdy);
        end
        tick();
        row_rdy_drv   = 1'b0;
        i_row_islast  = 1'b0;
        i_req_row_ack = '0;
    endtask

    task automatic test_contention();
        int   g, n, own, mptr;
        row_t e;
        i_rst = 1'b1;
        tick();
        i_rst     = 1'b0;
        i_req_rdy = 2'b11;
        mptr      = 0;
        for (int c = 0; c < 4; c++) begin
            own  = mptr;
            mptr = (mptr + 1) % NREQ;
            exp_grant.push_back(own);
            #1;
            n = 0;
            while (o_req_ack === '0 && n < 8) begin
                tick();
                #1;
                n++;
            end
            g = exp_grant.pop_front();
            checks++;
            if (o_req_ack !== (NREQ'(1) << g)) begin
                errors++;
                $display("FAIL contention_grant[%0d]: got %b want %b", c, o_req_ack, NREQ'(1) << g);
            end
            tick();
            i_dp_ack = 1'b1;
            tick();
            i_dp_ack = 1'b0;
            for (int r = 0; r < 3; r++) begin
                i_row_linear  = GBW'(own*256 + c*16 + r);
                i_row_pad     = V_BW'(r + 1);
                i_row_valid   = 1'b1;
                i_row_islast  = (r == 2);
                row_rdy_drv   = 1'b1;
                i_req_row_ack = '1;
                e.own = own;
                e.lin = i_row_linear;
                e.pad = i_row_pad;
                exp_row.push_back(e);
                #1;
                checks++;
                if (o_row_ack === 1'b1 && i_row_rdy === 1'b1) begin
                    e = exp_row.pop_front();
                    if (o_req_row_rdy !== (NREQ'(1) << e.own) || o_req_row_linear !== e.lin ||
                        o_req_row_pad !== e.pad || o_req_row_valid !== 1'b1) begin
                        errors++;
                        $display("FAIL contention_row[%0d.%0d]: rdy=%b lin=%h pad=%0d want rdy=%b lin=%h pad=%0d",
                                 c, r, o_req_row_rdy, o_req_row_linear, o_req_row_pad,
                                 NREQ'(1) << e.own, e.lin, e.pad);
                    end
                end else begin
                    errors++;
                    $display("FAIL contention_row[%0d.%0d]: no transfer, row_ack=%b want 1", c, r, o_row_ack);
                end
                tick();
            end
            row_rdy_drv   = 1'b0;
            i_row_islast  = 1'b0;
            i_row_valid   = 1'b0;
            i_req_row_ack = '0;
            #1;
            checks++;
            if (o_busy !== 1'b0) begin
                errors++;
                $display("FAIL contention_idle[%0d]: busy=%b want 0", c, o_busy);
            end
        end
        i_req_rdy = '0;
`ifdef CHUNK_ROW_SCHED_PERF_EN
        checks++;
        if (o_perf_rows[0] !== 32'd6 || o_perf_rows[1] !== 32'd6) begin
            errors++;
            $display("FAIL perf_rows: got %0d/%0d want 6/6", o_perf_rows[0], o_perf_rows[1]);
        end
`endif
    endtask

    task automatic test_back_to_back();
        logic [NREQ-1:0] e;
        tick();
        i_req_rdy     = 2'b10;
        i_dp_ack      = 1'b1;
        i_row_islast  = 1'b1;
        i_req_row_ack = 2'b10;
        auto_row      = 1'b1;
        for (int cyc = 0; cyc < 12; cyc++) begin
            exp_ack.push_back((cyc % 3 == 0) ? 2'b10 : 2'b00);
            #1;
            e = exp_ack.pop_front();
            checks++;
            if (o_req_ack !== e) begin
                errors++;
                $display("FAIL b2b_ack[cyc %0d]: got %b want %b", cyc, o_req_ack, e);
            end
            tick();
        end
        i_req_rdy     = '0;
        i_dp_ack      = 1'b0;
        i_row_islast  = 1'b0;
        i_req_row_ack = '0;
        auto_row      = 1'b0;
    endtask

    task automatic test_cfg_stability();
        int                g;
        logic [CFG_BW-1:0] held;
        held         = mk_cfg(16'h0100, 8'h33);
        i_req_cfg[0] = held;
        i_req_rdy    = 2'b01;
        exp_grant.push_back(0);
        #1;
        g = exp_grant.pop_front();
        checks++;
        if (o_req_ack !== (NREQ'(1) << g)) begin
            errors++;
            $display("FAIL cfg_grant: got %b want %b", o_req_ack, NREQ'(1) << g);
        end
        tick();
        i_req_rdy = '0;
        #1;
        checks++;
        if (o_dp_cfg !== held) begin
            errors++;
            $display("FAIL cfg_issue: maddr=%h want 0100", o_dp_cfg[GBW:1]);
        end
        i_dp_ack = 1'b1;
        tick();
        i_dp_ack     = 1'b0;
        i_req_cfg[0] = mk_cfg(16'h0200, 8'h44);
        for (int r = 0; r < 3; r++) begin
            row_rdy_drv   = 1'b1;
            i_row_islast  = (r == 2);
            i_req_row_ack = 2'b01;
            #1;
            checks++;
            if (o_dp_cfg !== held) begin
                errors++;
                $display("FAIL cfg_drain[%0d]: maddr=%h want 0100", r, o_dp_cfg[GBW:1]);
            end
            tick();
        end
        row_rdy_drv   = 1'b0;
        i_row_islast  = 1'b0;
        i_req_row_ack = '0;
    endtask

    task automatic test_backpressure();
        int   g;
        row_t e;
        tick();
        i_req_rdy = 2'b01;
        exp_grant.push_back(0);
        #1;
        g = exp_grant.pop_front();
        checks++;
        if (o_req_ack !== (NREQ'(1) << g)) begin
            errors++;
            $display("FAIL bp_grant: got %b want %b", o_req_ack, NREQ'(1) << g);
        end
        tick();
        i_req_rdy = '0;
        i_dp_ack  = 1'b1;
        tick();
        i_dp_ack      = 1'b0;
        i_row_linear  = 16'h0abc;
        i_row_pad     = 3'd5;
        i_row_islast  = 1'b1;
        row_rdy_drv   = 1'b1;
        i_req_row_ack = 2'b10;
        e.own = 0;
        e.lin = 16'h0abc;
        e.pad = 3'd5;
        exp_row.push_back(e);
        for (int k = 0; k < 4; k++) begin
            #1;
            checks++;
            if (o_row_ack !== 1'b0 || o_req_row_rdy !== 2'b01 ||
                o_req_row_linear !== 16'h0abc || o_busy !== 1'b1) begin
                errors++;
                $display("FAIL bp_stall[%0d]: row_ack=%b rdy=%b lin=%h busy=%b want 0/01/0abc/1",
                         k, o_row_ack, o_req_row_rdy, o_req_row_linear, o_busy);
            end
            tick();
        end
        i_req_row_ack = 2'b01;
        #1;
        checks++;
        if (o_row_ack === 1'b1 && i_row_rdy === 1'b1) begin
            e = exp_row.pop_front();
            if (o_req_row_rdy !== (NREQ'(1) << e.own) || o_req_row_linear !== e.lin || o_req_row_pad !== e.pad) begin
                errors++;
                $display("FAIL bp_release: rdy=%b lin=%h pad=%0d want %b/%h/%0d",
                         o_req_row_rdy, o_req_row_linear, o_req_row_pad, NREQ'(1) << e.own, e.lin, e.pad);
            end
        end else begin
            errors++;
            $display("FAIL bp_release: row_ack=%b want 1", o_row_ack);
        end
        tick();
        row_rdy_drv   = 1'b0;
        i_row_islast  = 1'b0;
        i_req_row_ack = '0;
        #1;
        checks++;
        if (o_busy !== 1'b0) begin
            errors++;
            $display("FAIL bp_idle: busy=%b want 0", o_busy);
        end
    endtask

    task automatic test_reset_mid_drain();
        int   g;
        row_t e;
        tick();
        i_req_rdy = 2'b01;
        exp_grant.push_back(0);
        #1;
        g = exp_grant.pop_front();
        checks++;
        if (o_req_ack !== (NREQ'(1) << g)) begin
            errors++;
            $display("FAIL mid_grant: got %b want %b", o_req_ack, NREQ'(1) << g);
        end
        tick();
        i_req_rdy = '0;
        i_dp_ack  = 1'b1;
        tick();
        i_dp_ack = 1'b0;
        for (int r = 0; r < 2; r++) begin
            i_row_linear  = GBW'(16'h0500 + r);
            i_row_pad     = '0;
            i_row_islast  = 1'b0;
            row_rdy_drv   = 1'b1;
            i_req_row_ack = 2'b01;
            e.own = 0;
            e.lin = i_row_linear;
            e.pad = '0;
            exp_row.push_back(e);
            #1;
            checks++;
            if (o_row_ack === 1'b1) begin
                e = exp_row.pop_front();
                if (o_req_row_rdy !== (NREQ'(1) << e.own) || o_req_row_linear !== e.lin) begin
                    errors++;
                    $display("FAIL mid_row[%0d]: rdy=%b lin=%h want %b/%h",
                             r, o_req_row_rdy, o_req_row_linear, NREQ'(1) << e.own, e.lin);
                end
            end else begin
                errors++;
                $display("FAIL mid_row[%0d]: row_ack=%b want 1", r, o_row_ack);
            end
            tick();
        end
        i_rst         = 1'b1;
        row_rdy_drv   = 1'b0;
        i_req_row_ack = '0;
        tick();
        #1;
        checks++;
        if (o_busy !== 1'b0 || o_req_row_rdy !== 2'b00 || o_dp_rdy !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset: busy=%b row_rdy=%b dp_rdy=%b want 0/00/0", o_busy, o_req_row_rdy, o_dp_rdy);
        end
`ifdef CHUNK_ROW_SCHED_PERF_EN
        checks++;
        if (o_perf_rows !== '0 || o_perf_wait !== '0) begin
            errors++;
            $display("FAIL perf_cleared: rows=%h wait=%h want 0", o_perf_rows, o_perf_wait);
        end
`endif
        i_rst     = 1'b0;
        i_req_rdy = 2'b11;
        exp_grant.push_back(0);
        #1;
        g = exp_grant.pop_front();
        checks++;
        if (o_req_ack !== (NREQ'(1) << g)) begin
            errors++;
            $display("FAIL mid_ptr_reset: got %b want %b", o_req_ack, NREQ'(1) << g);
        end
        tick();
        i_req_rdy = '0;
    endtask

    initial begin
        test_reset();
        test_contention();
        test_back_to_back();
        test_cfg_stability();
        test_backpressure();
        test_reset_mid_drain();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1);
    end

endmodule
